// File: rtl/reg_scoreboard.sv
// Register scoreboard: one saturating in-flight write counter per architectural register.
// Decode is stalled on RAW/WAW hazards; the writeback port is snooped to retire writes.
module reg_scoreboard #(
  parameter int ADDRESS_WIDTH = 5,
  parameter int CNT_WIDTH     = 2,
  parameter int TOT_WIDTH     = 6
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        issue_valid,
  input  logic [ADDRESS_WIDTH-1:0]    issue_rs1,
  input  logic [ADDRESS_WIDTH-1:0]    issue_rs2,
  input  logic                        use_rs1,
  input  logic                        use_rs2,
  input  logic                        issue_we,
  input  logic [ADDRESS_WIDTH-1:0]    issue_rd,
  input  logic                        wb_we,
  input  logic [ADDRESS_WIDTH-1:0]    wb_rd,
  output logic                        stall,
  output logic                        issue_fire,
  output logic [2**ADDRESS_WIDTH-1:0] busy,
  output logic [TOT_WIDTH-1:0]        inflight,
  output logic                        wb_err
);

  localparam int NREG = 2**ADDRESS_WIDTH;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};
  localparam logic [TOT_WIDTH-1:0] TOT_MAX = {TOT_WIDTH{1'b1}};

  logic [CNT_WIDTH-1:0] cnt_q [NREG];
  logic [CNT_WIDTH-1:0] cnt_d [NREG];
  logic [TOT_WIDTH-1:0] inflight_q, inflight_d;
  logic                 wb_err_q, wb_err_d;

  logic rd_nz, wb_nz, inc_any, dec_any, wb_spurious;
  logic raw_hit, waw_full;

  always_comb begin
    busy = '0;
    for (int r = 1; r < NREG; r++) busy[r] = (cnt_q[r] != '0);
  end

  // Hazard check uses registered state only; a same-cycle writeback does not release decode.
  always_comb begin
    rd_nz    = (issue_rd != '0);
    raw_hit  = (use_rs1 && busy[issue_rs1]) || (use_rs2 && busy[issue_rs2]);
    waw_full = issue_we && rd_nz && ((cnt_q[issue_rd] == CNT_MAX) || (inflight_q == TOT_MAX));
    stall      = issue_valid && (raw_hit || waw_full);
    issue_fire = issue_valid && !stall;
  end

  always_comb begin
    wb_nz       = (wb_rd != '0);
    inc_any     = issue_fire && issue_we && rd_nz;
    dec_any     = wb_we && wb_nz && (cnt_q[wb_rd] != '0);
    wb_spurious = wb_we && wb_nz && (cnt_q[wb_rd] == '0);

    cnt_d[0] = '0;
    for (int r = 1; r < NREG; r++) begin
      cnt_d[r] = cnt_q[r];
      if (inc_any && (issue_rd == ADDRESS_WIDTH'(r)) && !(dec_any && (wb_rd == ADDRESS_WIDTH'(r))))
        cnt_d[r] = cnt_q[r] + CNT_WIDTH'(1);
      else if (dec_any && (wb_rd == ADDRESS_WIDTH'(r)) && !(inc_any && (issue_rd == ADDRESS_WIDTH'(r))))
        cnt_d[r] = cnt_q[r] - CNT_WIDTH'(1);
    end

    inflight_d = inflight_q;
    if (inc_any && !dec_any)      inflight_d = inflight_q + TOT_WIDTH'(1);
    else if (dec_any && !inc_any) inflight_d = inflight_q - TOT_WIDTH'(1);

    wb_err_d = wb_err_q || wb_spurious;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NREG; r++) cnt_q[r] <= '0;
      inflight_q <= '0;
      wb_err_q   <= 1'b0;
    end else begin
      for (int r = 0; r < NREG; r++) cnt_q[r] <= cnt_d[r];
      inflight_q <= inflight_d;
      wb_err_q   <= wb_err_d;
    end
  end

  assign inflight = inflight_q;
  assign wb_err   = wb_err_q;

endmodule
